// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake state, machine word and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT,
    ERR
  } arb_state_t;

  localparam int unsigned ARB_DATA_PRIO_MAX = 4;
  localparam int unsigned ARB_TIMEOUT       = 16;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of every signal crossing the memory arbiter, with one view per attached party.
interface memory_arbiter_if
  import cpu_types_pkg::*;
(
  input logic CLK
);
  logic      RST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      arb_err;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport cache (
    input  CLK, iwait, iload, dwait, dload, arb_err,
    output iREN, iaddr, dREN, dWEN, daddr, dstore
  );

  modport ram (
    input  CLK, ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

  modport tb (
    input  CLK, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err,
    output RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
  );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear and enable; tc_o flags the saturation value.
module arb_sat_counter #(
  parameter int unsigned Width = 4,
  parameter int unsigned Max   = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == MaxVal);

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data requests win, instruction fetch is forced after a bounded
// run of data grants, and a stalled or faulting RAM latches a sticky error.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_PRIO_MAX = ARB_DATA_PRIO_MAX,
  parameter int unsigned TIMEOUT       = ARB_TIMEOUT
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  localparam int unsigned StarveW = $clog2(DATA_PRIO_MAX + 1);
  localparam int unsigned TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       starve_clr, starve_inc, starve_tc;
  logic       tmo_clr, tmo_en, tmo_tc;

  assign d_req = dREN | dWEN;

  arb_sat_counter #(
    .Width (StarveW),
    .Max   (DATA_PRIO_MAX)
  ) u_starve (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (starve_clr),
    .en_i  (starve_inc),
    .tc_o  (starve_tc)
  );

  arb_sat_counter #(
    .Width (TmoW),
    .Max   (TIMEOUT - 1)
  ) u_tmo (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d    = state_q;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    starve_clr = 1'b0;
    starve_inc = 1'b0;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_clr = 1'b1;
        // starve_tc means starve_cnt has reached DATA_PRIO_MAX
        if (d_req && (!iREN || !starve_tc)) begin
          state_d    = DGRANT;
          starve_inc = iREN;
        end else if (iREN) begin
          state_d    = IGRANT;
          starve_clr = 1'b1;
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          case (ramstate)
            ACCESS: begin
              iwait   = 1'b0;
              iload   = ramload;
              state_d = IDLE;
            end
            ERROR:   state_d = ERR;
            default: begin
              tmo_en = 1'b1;
              if (tmo_tc) state_d = ERR;
            end
          endcase
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          case (ramstate)
            ACCESS: begin
              dwait   = 1'b0;
              dload   = ramload;
              state_d = IDLE;
            end
            ERROR:   state_d = ERR;
            default: begin
              tmo_en = 1'b1;
              if (tmo_tc) state_d = ERR;
            end
          endcase
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Reset kills an in-flight grant in the same cycle it is sampled
    if (RST) begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign arb_err = (state_q == ERR) & ~RST;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-cycle vector table plus hand-built corner sequences.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if bus (.CLK(clk));

  memory_arbiter dut (
    .CLK      (clk),
    .RST      (bus.RST),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .iwait    (bus.iwait),
    .iload    (bus.iload),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .dwait    (bus.dwait),
    .dload    (bus.dload),
    .ramREN   (bus.ramREN),
    .ramWEN   (bus.ramWEN),
    .ramaddr  (bus.ramaddr),
    .ramstore (bus.ramstore),
    .ramload  (bus.ramload),
    .ramstate (bus.ramstate),
    .arb_err  (bus.arb_err)
  );

  typedef struct {
    logic      rst, ir, dr, dw;
    word_t     ia, da, ds;
    ramstate_t rs;
    word_t     rl;
    logic      e_ren, e_wen;
    word_t     e_addr, e_store;
    logic      e_iw, e_dw;
    word_t     e_il, e_dl;
    logic      e_err;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t v(logic rst, logic ir, logic dr, logic dw, word_t ia, word_t da,
                             word_t ds, ramstate_t rs, word_t rl, logic ren, logic wen,
                             word_t addr, word_t store, logic iw, logic dwt, word_t il,
                             word_t dl, logic err);
    vec_t r;
    r.rst = rst;  r.ir = ir;  r.dr = dr;  r.dw = dw;
    r.ia = ia;  r.da = da;  r.ds = ds;  r.rs = rs;  r.rl = rl;
    r.e_ren = ren;  r.e_wen = wen;  r.e_addr = addr;  r.e_store = store;
    r.e_iw = iw;  r.e_dw = dwt;  r.e_il = il;  r.e_dl = dl;  r.e_err = err;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_in(logic rst, logic ir, logic dr, logic dw, ramstate_t rs, word_t rl);
    bus.RST = rst;  bus.iREN = ir;  bus.dREN = dr;  bus.dWEN = dw;
    bus.ramstate = rs;  bus.ramload = rl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, FREE, '0);
    cyc();
  endtask

  vec_t tbl[14];

  initial begin
    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dstore = '0;

    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    // single fetch, ACCESS on second grant cycle
    tbl[1]  = v(0, 1, 0, 0, 32'h40, 0, 0, FREE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[2]  = v(0, 1, 0, 0, 32'h40, 0, 0, BUSY, 0, 1, 0, 32'h40, 0, 1, 1, 0, 0, 0);
    tbl[3]  = v(0, 1, 0, 0, 32'h40, 0, 0, ACCESS, 32'h2408_0001, 1, 0, 32'h40, 0,
                0, 1, 32'h2408_0001, 0, 0);
    tbl[4]  = v(0, 0, 0, 0, 32'h40, 0, 0, FREE, 32'h2408_0001, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    // write wins over read
    tbl[5]  = v(0, 0, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, FREE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = v(0, 0, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, ACCESS, 32'h1234_5678, 0, 1, 32'h100,
                32'hDEAD_BEEF, 1, 0, 0, 32'h1234_5678, 0);
    tbl[7]  = v(0, 0, 0, 0, 0, 32'h100, 32'hDEAD_BEEF, FREE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    // data abort, then the pending fetch
    tbl[8]  = v(0, 1, 1, 0, 32'h44, 32'h200, 0, FREE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[9]  = v(0, 1, 1, 0, 32'h44, 32'h200, 0, BUSY, 0, 1, 0, 32'h200, 0, 1, 1, 0, 0, 0);
    tbl[10] = v(0, 1, 0, 0, 32'h44, 32'h200, 0, BUSY, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[11] = v(0, 1, 0, 0, 32'h44, 32'h200, 0, FREE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[12] = v(0, 1, 0, 0, 32'h44, 32'h200, 0, ACCESS, 32'hCAFE_0001, 1, 0, 32'h44, 0,
                0, 1, 32'hCAFE_0001, 0, 0);
    tbl[13] = v(0, 0, 0, 0, 32'h44, 32'h200, 0, ACCESS, 32'hCAFE_0001, 0, 0, 0, 0,
                1, 1, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].rst, tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].rs, tbl[i].rl);
      bus.iaddr = tbl[i].ia;  bus.daddr = tbl[i].da;  bus.dstore = tbl[i].ds;
      #1;
      chk($sformatf("row%0d ramREN", i),   32'(bus.ramREN),  32'(tbl[i].e_ren));
      chk($sformatf("row%0d ramWEN", i),   32'(bus.ramWEN),  32'(tbl[i].e_wen));
      chk($sformatf("row%0d ramaddr", i),  bus.ramaddr,      tbl[i].e_addr);
      chk($sformatf("row%0d ramstore", i), bus.ramstore,     tbl[i].e_store);
      chk($sformatf("row%0d iwait", i),    32'(bus.iwait),   32'(tbl[i].e_iw));
      chk($sformatf("row%0d dwait", i),    32'(bus.dwait),   32'(tbl[i].e_dw));
      chk($sformatf("row%0d iload", i),    bus.iload,        tbl[i].e_il);
      chk($sformatf("row%0d dload", i),    bus.dload,        tbl[i].e_dl);
      chk($sformatf("row%0d arb_err", i),  32'(bus.arb_err), 32'(tbl[i].e_err));
      cyc();
    end

    // Priority and starvation: expect D,D,D,D,I repeating
    do_reset();
    bus.iaddr = 32'h80;  bus.daddr = 32'h300;  bus.dstore = '0;
    for (int g = 0; g < 10; g++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, ACCESS, 32'h5);
      #1;
      chk($sformatf("prio%0d idle ramREN", g), 32'(bus.ramREN), 32'd0);
      if (g == 5) chk("starve after I", 32'(dut.u_starve.cnt_q), 32'd0);
      cyc();
      #1;
      if ((g % 5) == 4) begin
        chk($sformatf("prio%0d iwait", g), 32'(bus.iwait), 32'd0);
        chk($sformatf("prio%0d dwait", g), 32'(bus.dwait), 32'd1);
        chk($sformatf("prio%0d addr", g),  bus.ramaddr,    32'h80);
      end else begin
        chk($sformatf("prio%0d iwait", g), 32'(bus.iwait), 32'd1);
        chk($sformatf("prio%0d dwait", g), 32'(bus.dwait), 32'd0);
        chk($sformatf("prio%0d addr", g),  bus.ramaddr,    32'h300);
      end
      cyc();
    end
    #1;
    chk("starve after 2nd I", 32'(dut.u_starve.cnt_q), 32'd0);

    // Timeout: BUSY for 16 grant cycles
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, BUSY, '0);
    cyc();
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k == 1 || k == 16) begin
        chk($sformatf("tmo grant%0d ramREN", k), 32'(bus.ramREN),  32'd1);
        chk($sformatf("tmo grant%0d err", k),    32'(bus.arb_err), 32'd0);
      end
      cyc();
    end
    #1;
    chk("tmo err set",    32'(bus.arb_err), 32'd1);
    chk("tmo iwait",      32'(bus.iwait),   32'd1);
    chk("tmo dwait",      32'(bus.dwait),   32'd1);
    chk("tmo ramREN off", 32'(bus.ramREN),  32'd0);
    repeat (20) cyc();
    chk("tmo err sticky", 32'(bus.arb_err), 32'd1);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, BUSY, '0);
    #1;
    chk("tmo rst ramREN", 32'(bus.ramREN), 32'd0);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, FREE, '0);
    #1;
    chk("tmo err cleared", 32'(bus.arb_err), 32'd0);

    // RAM ERROR during a data grant
    cyc();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, FREE, 32'h77);
    cyc();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, ERROR, 32'h77);
    #1;
    chk("error grant ramREN", 32'(bus.ramREN), 32'd1);
    chk("error no dcompl",    32'(bus.dwait),  32'd1);
    cyc();
    chk("error err set", 32'(bus.arb_err), 32'd1);
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, ACCESS, 32'h99);
    #1;
    chk("post-err idle", 32'(bus.ramREN), 32'd0);
    chk("post-err flag", 32'(bus.arb_err), 32'd0);
    cyc();
    chk("post-err fetch iwait", 32'(bus.iwait), 32'd0);
    chk("post-err fetch iload", bus.iload,      32'h99);

    // Reset in the middle of a data grant
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, ACCESS, '0);
    repeat (4) cyc();
    chk("midrst starve=2", 32'(dut.u_starve.cnt_q), 32'd2);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, BUSY, '0);
    cyc();
    chk("midrst wen", 32'(bus.ramWEN), 32'd1);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, BUSY, '0);
    #1;
    chk("midrst wen off", 32'(bus.ramWEN), 32'd0);
    chk("midrst ren off", 32'(bus.ramREN), 32'd0);
    cyc();
    set_in(1'b0, 1'b1, 1'b1, 1'b1, ACCESS, '0);
    #1;
    chk("midrst starve=0", 32'(dut.u_starve.cnt_q), 32'd0);
    chk("midrst idle",     32'(bus.ramWEN),         32'd0);
    cyc();
    chk("midrst first D", 32'(bus.dwait), 32'd0);
    cyc();
    chk("midrst starve=1", 32'(dut.u_starve.cnt_q), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
